// File: rtl/async_fifo_pkg.sv
// Shared definitions for the asynchronous FIFO pointer blocks (read and write side).
// Gray/binary helpers operate on a wide vector; callers zero-extend and truncate.
package async_fifo_pkg;

    localparam int DEF_ADDRSIZE = 4;
    localparam int PTR_MAXW     = 32;

    function automatic logic [PTR_MAXW-1:0] bin2gray(input logic [PTR_MAXW-1:0] b);
        return (b >> 1) ^ b;
    endfunction

    // Zero-extended inputs give the correct low bits for any narrower pointer width.
    function automatic logic [PTR_MAXW-1:0] gray2bin(input logic [PTR_MAXW-1:0] g);
        logic [PTR_MAXW-1:0] b;
        b[PTR_MAXW-1] = g[PTR_MAXW-1];
        for (int i = PTR_MAXW - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/fifo_rptr_empty_if.sv
// Read-side handshake bundle between the read pointer block and its surroundings.
interface fifo_rptr_empty_if
    import async_fifo_pkg::*;
#(
    parameter int ADDRSIZE = DEF_ADDRSIZE
);
    logic                rinc;
    logic                aempty_n;
    logic                rempty;
    logic [ADDRSIZE-1:0] raddr;
    logic [ADDRSIZE-1:0] rptr;
    logic                runderflow;

    modport master (
        input  rinc,
        input  aempty_n,
        output rempty,
        output raddr,
        output rptr,
        output runderflow
    );

    modport slave (
        output rinc,
        output aempty_n,
        input  rempty,
        input  raddr,
        input  rptr,
        input  runderflow
    );
endinterface

// File: rtl/sync2_aset.sv
// Two-flop synchronizer whose output chain is forced high asynchronously by i_set_n.
// Metastability from a released set is confined to the first flop.
module sync2_aset (
    input  logic clk,
    input  logic i_set_n,
    input  logic i_d,
    output logic o_q
);
    logic r_meta;
    logic r_q;

    always_ff @(posedge clk or negedge i_set_n) begin
        if (!i_set_n) begin
            r_meta <= 1'b1;
            r_q    <= 1'b1;
        end else begin
            r_meta <= i_d;
            r_q    <= r_meta;
        end
    end

    assign o_q = r_q;
endmodule

// File: rtl/fifo_rptr_empty.sv
// Read pointer (binary + Gray) and glitch-free empty flag for the asynchronous FIFO.
module fifo_rptr_empty
    import async_fifo_pkg::*;
#(
    parameter int ADDRSIZE = DEF_ADDRSIZE
) (
    input  logic              rclk,
    input  logic              rrst_n,
    fifo_rptr_empty_if.master bus
);
    logic [ADDRSIZE-1:0] r_rbin;
    logic [ADDRSIZE-1:0] r_rptr;
    logic                r_runderflow;
    logic [ADDRSIZE-1:0] w_rbnext;
    logic [ADDRSIZE-1:0] w_rgnext;
    logic                w_rempty;
    logic                w_read;
    logic                w_set_n;

    // Gating uses the registered flag, so a read racing an empty assertion is still judged by it.
    assign w_read   = bus.rinc & ~w_rempty;
    assign w_rbnext = r_rbin + ADDRSIZE'(w_read);
    assign w_rgnext = ADDRSIZE'(bin2gray(PTR_MAXW'(w_rbnext)));

    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            r_rbin       <= '0;
            r_rptr       <= '0;
            r_runderflow <= 1'b0;
        end else begin
            r_rbin <= w_rbnext;
            r_rptr <= w_rgnext;
            if (bus.rinc && w_rempty) begin
                r_runderflow <= 1'b1;
            end
        end
    end

    // Reset and comparator-empty both force the flag chain high without a clock.
    assign w_set_n = bus.aempty_n & rrst_n;

    sync2_aset u_empty_sync (
        .clk     (rclk),
        .i_set_n (w_set_n),
        .i_d     (1'b0),
        .o_q     (w_rempty)
    );

    assign bus.rempty     = w_rempty;
    assign bus.raddr      = r_rbin;
    assign bus.rptr       = r_rptr;
    assign bus.runderflow = r_runderflow;
endmodule

// File: tb/tb_fifo_rptr_empty.sv
// Bench for fifo_rptr_empty: directed scenarios plus randomized traffic against a read-count model.
module tb_fifo_rptr_empty;
    localparam int AW    = 4;
    localparam int DEPTH = 1 << AW;

    logic rclk   = 1'b0;
    logic rrst_n = 1'b0;

    fifo_rptr_empty_if #(.ADDRSIZE(AW)) bus();

    fifo_rptr_empty #(.ADDRSIZE(AW)) dut (
        .rclk   (rclk),
        .rrst_n (rrst_n),
        .bus    (bus)
    );

    always #5 rclk = ~rclk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: number of accepted reads, sticky underflow, and clean edges seen since empty was last forced.
    int m_reads    = 0;
    bit m_und      = 1'b0;
    int m_cnt      = 0;
    int low_events = 0;
    int seen_low   = 0;
    int rst_events = 0;
    int seen_rst   = 0;

    always @(negedge bus.aempty_n) low_events++;
    always @(negedge rrst_n) rst_events++;

    always @(posedge rclk) begin
        bit pre_empty;
        if (rst_events != seen_rst) begin
            m_reads = 0;
            m_und   = 1'b0;
            m_cnt   = 0;
        end
        if (low_events != seen_low) m_cnt = 0;
        seen_rst = rst_events;
        seen_low = low_events;
        if (!rrst_n) begin
            m_reads = 0;
            m_und   = 1'b0;
            m_cnt   = 0;
        end else begin
            pre_empty = !bus.aempty_n || (m_cnt < 2);
            if (bus.rinc && !pre_empty) m_reads = (m_reads + 1) % DEPTH;
            if (bus.rinc && pre_empty)  m_und = 1'b1;
            m_cnt = bus.aempty_n ? ((m_cnt < 2) ? m_cnt + 1 : 2) : 0;
        end
    end

    always @(negedge rclk) begin
        int e_addr;
        bit e_empty;
        bit e_und;
        if (!rrst_n || rst_events != seen_rst) begin
            e_addr  = 0;
            e_empty = 1'b1;
            e_und   = 1'b0;
        end else begin
            e_addr  = m_reads;
            e_empty = !bus.aempty_n || (m_cnt < 2) || (low_events != seen_low);
            e_und   = m_und;
        end
        check("model_raddr",      int'(bus.raddr),      e_addr);
        check("model_rptr",       int'(bus.rptr),       e_addr ^ (e_addr >> 1));
        check("model_rempty",     int'(bus.rempty),     int'(e_empty));
        check("model_runderflow", int'(bus.runderflow), int'(e_und));
    end

    task automatic tick();
        @(posedge rclk);
        #2;
    endtask

    initial begin
        logic [AW-1:0] prev_ptr;
        int r;
        bus.rinc     = 1'b0;
        bus.aempty_n = 1'b0;
        rrst_n       = 1'b0;
        repeat (3) tick();
        check("rst_raddr",      int'(bus.raddr),      0);
        check("rst_rptr",       int'(bus.rptr),       0);
        check("rst_rempty",     int'(bus.rempty),     1);
        check("rst_runderflow", int'(bus.runderflow), 0);
        rrst_n = 1'b1;
        tick();
        check("rel_empty_held", int'(bus.rempty), 1);
        bus.aempty_n = 1'b1;
        tick();
        check("clear_edge1", int'(bus.rempty), 1);
        tick();
        check("clear_edge2", int'(bus.rempty), 0);

        // Sequential reads across the wrap.
        bus.rinc = 1'b1;
        prev_ptr = bus.rptr;
        for (int i = 1; i <= DEPTH; i++) begin
            tick();
            check("seq_raddr", int'(bus.raddr), i % DEPTH);
            check("seq_gray_step", $countones(bus.rptr ^ prev_ptr), 1);
            if (i == DEPTH - 1) check("wrap_gray_top", int'(bus.rptr), 8);
            prev_ptr = bus.rptr;
        end
        check("wrap_gray_zero", int'(bus.rptr), 0);
        bus.rinc = 1'b0;

        // Underflow attempt while empty.
        bus.aempty_n = 1'b0;
        #1;
        check("uf_empty", int'(bus.rempty), 1);
        tick();
        bus.rinc = 1'b1;
        tick();
        bus.rinc = 1'b0;
        check("uf_set",   int'(bus.runderflow), 1);
        check("uf_raddr", int'(bus.raddr),      0);
        repeat (2) tick();
        check("uf_sticky", int'(bus.runderflow), 1);
        bus.aempty_n = 1'b1;
        repeat (2) tick();
        check("uf_clear_empty", int'(bus.rempty), 0);

        // Asynchronous empty blocks a held read.
        bus.rinc = 1'b1;
        repeat (5) tick();
        check("ae_pre_raddr", int'(bus.raddr), 5);
        #1;
        bus.aempty_n = 1'b0;
        #1;
        check("ae_async_empty", int'(bus.rempty), 1);
        repeat (2) tick();
        check("ae_raddr_hold", int'(bus.raddr), 5);
        bus.rinc     = 1'b0;
        bus.aempty_n = 1'b1;
        repeat (2) tick();
        check("ae_recover", int'(bus.rempty), 0);

        // Narrow pulse of 0.3 period between edges.
        #1;
        bus.aempty_n = 1'b0;
        #3;
        bus.aempty_n = 1'b1;
        check("np_caught", int'(bus.rempty), 1);
        tick();
        check("np_edge1", int'(bus.rempty), 1);
        tick();
        check("np_edge2", int'(bus.rempty), 0);

        // Reset in the middle of a read stream.
        bus.rinc = 1'b1;
        repeat (4) tick();
        check("mr_pre_raddr", int'(bus.raddr), 9);
        #1;
        rrst_n   = 1'b0;
        bus.rinc = 1'b0;
        #1;
        check("mr_raddr",  int'(bus.raddr),      0);
        check("mr_rptr",   int'(bus.rptr),       0);
        check("mr_rempty", int'(bus.rempty),     1);
        check("mr_uf",     int'(bus.runderflow), 0);
        repeat (2) tick();
        rrst_n = 1'b1;
        repeat (2) tick();
        check("mr_release_empty", int'(bus.rempty), 0);
        bus.rinc = 1'b1;
        tick();
        check("mr_resume", int'(bus.raddr), 1);

        // Randomized traffic; the per-cycle compare process does the checking.
        for (int c = 0; c < 800; c++) begin
            r        = $urandom_range(0, 99);
            bus.rinc = 1'($urandom_range(0, 1));
            rrst_n   = (r == 50) ? 1'b0 : 1'b1;
            if (bus.aempty_n && r < 6)       bus.aempty_n = 1'b0;
            else if (!bus.aempty_n && r < 40) bus.aempty_n = 1'b1;
            if (bus.aempty_n && r >= 92) begin
                #4;
                bus.aempty_n = 1'b0;
                #2;
                bus.aempty_n = 1'b1;
            end
            tick();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
